frog_game_logic: RTL and testbench



---
 rtl/frog_game_logic_pkg.sv | 30 +++
 rtl/frog_game_logic_key_edge_detect.sv | 24 ++
 rtl/frog_game_logic.sv | 140 ++++++++++++++
 tb/tb_frog_game_logic.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/frog_game_logic_pkg.sv
// Shared constants and state encoding for the frog game logic and draw datapath.
package frog_game_logic_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_REDRAW = 2'd2,
        S_OVER   = 2'd3
    } game_state_t;

    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;
    localparam int unsigned SPRITE_W = 32;
    localparam int unsigned SPRITE_H = 24;

    localparam int unsigned POS_W = 9;
    localparam int unsigned CNT_W = 4;

    // Increment that holds at the ceiling instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic [CNT_W-1:0] ceil);
        return (v >= ceil) ? ceil : v + CNT_W'(1);
    endfunction

    // Decrement that holds at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

endpackage

// File: rtl/frog_game_logic_key_edge_detect.sv
// Rising-edge detector for a bundle of level inputs; one history flop per bit.
module key_edge_detect #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev;

    // Remember last cycle's level so a held key only fires once.
    always_ff @(posedge clk) begin
        if (reset) prev <= '0;
        else       prev <= level;
    end

    // Rise is combinational so the move lands on the same edge the key is first seen.
    always_comb begin
        rise = level & ~prev;
    end

endmodule

// File: rtl/frog_game_logic.sv
// Game-state stage: frog position, score, lives, game-over and redraw handshake.
module frog_game_logic
    import frog_game_logic_pkg::*;
#(
    parameter int unsigned STEP_X     = SPRITE_W,
    parameter int unsigned STEP_Y     = SPRITE_H,
    parameter int unsigned MAX_X      = SCREEN_W,
    parameter int unsigned MAX_Y      = SCREEN_H,
    parameter int unsigned START_X    = 144,
    parameter int unsigned START_Y    = 216,
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned SCORE_MAX  = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    input  logic             hit,
    input  logic             redraw_ack,
    output logic [POS_W-1:0] frog_x,
    output logic [POS_W-1:0] frog_y,
    output logic [CNT_W-1:0] score,
    output logic [CNT_W-1:0] lives,
    output logic             game_over,
    output logic             redraw_req
);

    localparam logic [POS_W-1:0] STEP_X_P  = POS_W'(STEP_X);
    localparam logic [POS_W-1:0] STEP_Y_P  = POS_W'(STEP_Y);
    localparam logic [POS_W:0]   MAX_X_E   = (POS_W+1)'(MAX_X);
    localparam logic [POS_W:0]   MAX_Y_E   = (POS_W+1)'(MAX_Y);
    localparam logic [POS_W-1:0] START_X_P = POS_W'(START_X);
    localparam logic [POS_W-1:0] START_Y_P = POS_W'(START_Y);
    localparam logic [CNT_W-1:0] LIVES_P   = CNT_W'(LIVES_INIT);
    localparam logic [CNT_W-1:0] SCORE_P   = CNT_W'(SCORE_MAX);

    game_state_t      state, state_nxt;
    logic [POS_W-1:0] x_nxt, y_nxt;
    logic [CNT_W-1:0] score_nxt, lives_nxt;
    logic [4:0]       rise;
    logic             go_rise, up_rise, down_rise, left_rise, right_rise;

    key_edge_detect #(.W(5)) u_keys (
        .clk   (clk),
        .reset (reset),
        .level ({go, up, down, left, right}),
        .rise  (rise)
    );

    assign {go_rise, up_rise, down_rise, left_rise, right_rise} = rise;

    // State and game registers; reset overrides everything including a pending redraw.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            frog_x <= START_X_P;
            frog_y <= START_Y_P;
            score  <= '0;
            lives  <= LIVES_P;
        end else begin
            state  <= state_nxt;
            frog_x <= x_nxt;
            frog_y <= y_nxt;
            score  <= score_nxt;
            lives  <= lives_nxt;
        end
    end

    // Next-state, move arbitration (hit > up > down > left > right) and bounds.
    always_comb begin
        state_nxt = state;
        x_nxt     = frog_x;
        y_nxt     = frog_y;
        score_nxt = score;
        lives_nxt = lives;
        unique case (state)
            S_IDLE: begin
                if (go_rise) state_nxt = S_REDRAW;
            end
            S_PLAY: begin
                if (hit) begin
                    lives_nxt = sat_dec(lives);
                    x_nxt     = START_X_P;
                    y_nxt     = START_Y_P;
                    state_nxt = S_REDRAW;
                end else if (up_rise) begin
                    if (frog_y >= STEP_Y_P) begin
                        if (frog_y == STEP_Y_P) begin
                            // Reaching the top row scores and respawns in one step.
                            score_nxt = sat_inc(score, SCORE_P);
                            x_nxt     = START_X_P;
                            y_nxt     = START_Y_P;
                        end else begin
                            y_nxt = frog_y - STEP_Y_P;
                        end
                        state_nxt = S_REDRAW;
                    end
                end else if (down_rise) begin
                    if ({1'b0, frog_y} + {1'b0, STEP_Y_P} < MAX_Y_E) begin
                        y_nxt     = frog_y + STEP_Y_P;
                        state_nxt = S_REDRAW;
                    end
                end else if (left_rise) begin
                    if (frog_x >= STEP_X_P) begin
                        x_nxt     = frog_x - STEP_X_P;
                        state_nxt = S_REDRAW;
                    end
                end else if (right_rise) begin
                    if ({1'b0, frog_x} + {1'b0, STEP_X_P} < MAX_X_E) begin
                        x_nxt     = frog_x + STEP_X_P;
                        state_nxt = S_REDRAW;
                    end
                end
            end
            S_REDRAW: begin
                if (redraw_ack) state_nxt = (lives == '0) ? S_OVER : S_PLAY;
            end
            S_OVER: begin
                if (go_rise) begin
                    x_nxt     = START_X_P;
                    y_nxt     = START_Y_P;
                    score_nxt = '0;
                    lives_nxt = LIVES_P;
                    state_nxt = S_REDRAW;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decode straight from the state register.
    always_comb begin
        redraw_req = (state == S_REDRAW);
        game_over  = (state == S_OVER);
    end

endmodule

// File: tb/tb_frog_game_logic.sv
// Directed self-checking bench for frog_game_logic.
module tb_frog_game_logic;

    logic       clk = 1'b0;
    logic       reset, go, up, down, left, right, hit, redraw_ack;
    logic [8:0] frog_x, frog_y;
    logic [3:0] score, lives;
    logic       game_over, redraw_req;

    int errors = 0;
    int checks = 0;

    frog_game_logic dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .hit        (hit),
        .redraw_ack (redraw_ack),
        .frog_x     (frog_x),
        .frog_y     (frog_y),
        .score      (score),
        .lives      (lives),
        .game_over  (game_over),
        .redraw_req (redraw_req)
    );

    always #10 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Key codes: 0 go, 1 up, 2 down, 3 left, 4 right, 5 hit
    task automatic pulse(input int k);
        case (k)
            0: go = 1'b1;
            1: up = 1'b1;
            2: down = 1'b1;
            3: left = 1'b1;
            4: right = 1'b1;
            default: hit = 1'b1;
        endcase
        tick();
        go = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; hit = 1'b0;
    endtask

    task automatic ack();
        redraw_ack = 1'b1;
        tick();
        redraw_ack = 1'b0;
    endtask

    task automatic move_acked(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            pulse(k);
            ack();
        end
    endtask

    task automatic check_all(input string tag, input int x, input int y, input int s,
                             input int l, input int ov, input int rq);
        check({tag, ".x"}, int'(frog_x), x);
        check({tag, ".y"}, int'(frog_y), y);
        check({tag, ".score"}, int'(score), s);
        check({tag, ".lives"}, int'(lives), l);
        check({tag, ".over"}, int'(game_over), ov);
        check({tag, ".req"}, int'(redraw_req), rq);
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        hit = 1'b0; redraw_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_all("reset", 144, 216, 0, 3, 0, 0);

        // Idle ignores moves
        pulse(1);
        check_all("idle_up", 144, 216, 0, 3, 0, 0);

        // Start game
        pulse(0);
        check_all("go", 144, 216, 0, 3, 0, 1);
        ack();
        check("go_ack.req", int'(redraw_req), 0);

        // Held right moves exactly once
        right = 1'b1;
        tick();
        check_all("right_hold", 176, 216, 0, 3, 0, 1);
        ack();
        for (int i = 0; i < 8; i++) tick();
        check_all("right_held", 176, 216, 0, 3, 0, 0);
        right = 1'b0;
        tick();

        // Right boundary
        move_acked(4, 4);
        check("right_edge.x", int'(frog_x), 304);
        pulse(4);
        check_all("right_block", 304, 216, 0, 3, 0, 0);

        // Left back and to the left boundary
        move_acked(3, 9);
        check("left_edge.x", int'(frog_x), 16);
        pulse(3);
        check_all("left_block", 16, 216, 0, 3, 0, 0);
        move_acked(4, 4);
        check("recentre.x", int'(frog_x), 144);

        // Bottom boundary
        pulse(2);
        check_all("down_block", 144, 216, 0, 3, 0, 0);

        // Climb to the top row, then score
        move_acked(1, 8);
        check_all("climb", 144, 24, 0, 3, 0, 0);
        pulse(1);
        check_all("goal1", 144, 216, 1, 3, 0, 1);
        ack();

        // Score saturation
        move_acked(1, 72);
        check("goal9.score", int'(score), 9);
        move_acked(1, 9);
        check_all("goal_sat", 144, 216, 9, 3, 0, 0);

        // Up beats left
        up = 1'b1; left = 1'b1;
        tick();
        up = 1'b0; left = 1'b0;
        check_all("up_left", 144, 192, 9, 3, 0, 1);
        ack();
        move_acked(3, 1);
        check("pre_hit.x", int'(frog_x), 112);

        // Hit beats down
        hit = 1'b1; down = 1'b1;
        tick();
        hit = 1'b0; down = 1'b0;
        check_all("hit_down", 144, 216, 9, 2, 0, 1);

        // Key rise during redraw is dropped
        pulse(1);
        check_all("redraw_drop", 144, 216, 9, 2, 0, 1);
        ack();
        tick();
        check_all("no_queue", 144, 216, 9, 2, 0, 0);

        // Second hit; extra hit while redrawing is ignored
        pulse(5);
        check("hit2.lives", int'(lives), 1);
        pulse(5);
        check_all("hit_in_redraw", 144, 216, 9, 1, 0, 1);
        ack();

        // Third hit -> game over after ack
        pulse(5);
        check_all("hit3", 144, 216, 9, 0, 0, 1);
        ack();
        check_all("over", 144, 216, 9, 0, 1, 0);
        pulse(1);
        check_all("over_up", 144, 216, 9, 0, 1, 0);
        pulse(5);
        check_all("over_hit", 144, 216, 9, 0, 1, 0);

        // Restart
        pulse(0);
        check_all("restart", 144, 216, 0, 3, 0, 1);
        ack();

        // Reset in the middle of a redraw
        move_acked(4, 1);
        pulse(1);
        check_all("pre_reset", 176, 192, 0, 3, 0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all("mid_reset", 144, 216, 0, 3, 0, 0);
        pulse(1);
        check_all("post_reset_idle", 144, 216, 0, 3, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
